// File: rtl/lagarto_v_pipeline_sequencer.sv
// Per-stage advance sequencer for the Lagarto V vector front latches: valid tracking,
// bubble-collapsing load chain, flush, and issue into a variable-latency execute unit.
module lagarto_v_pipeline_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int MAX_LATENCY = 32,
  parameter int LW          = $clog2(MAX_LATENCY)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  fetch_valid_i,
  output logic                  fetch_ready_o,
  input  logic                  flush_i,
  input  logic                  halt_i,
  input  logic [LW-1:0]         issue_latency_i,
  output logic [NUM_STAGES-1:0] stage_load_o,
  output logic [NUM_STAGES-1:0] stage_flush_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic                  exe_issue_o,
  output logic                  exe_busy_o,
  output logic                  halt_pipeline_o
);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] ready;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic                  freeze;
  logic                  issue;

  // Busy counter never wraps below zero.
  function automatic logic [LW-1:0] sat_dec(input logic [LW-1:0] v);
    return (v == '0) ? '0 : v - LW'(1);
  endfunction

  assign freeze = reset_i | flush_i | halt_i;
  assign issue  = valid_q[NUM_STAGES-1] & (cnt_q == '0) & ~freeze;

  // A stage may load when it or any stage downstream has a free slot this cycle.
  always_comb begin
    logic chain;
    ready = '0;
    chain = ~valid_q[NUM_STAGES-1] | issue;
    if (!freeze) begin
      ready[NUM_STAGES-1] = chain;
      for (int i = NUM_STAGES-2; i >= 0; i--) begin
        chain    = ~valid_q[i] | chain;
        ready[i] = chain;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      if (ready[0]) valid_d[0] = fetch_valid_i;
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (ready[i]) valid_d[i] = valid_q[i-1];
      end
    end
    cnt_d = issue ? issue_latency_i : sat_dec(cnt_q);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stage_load_o    = ready;
  assign stage_flush_o   = {NUM_STAGES{reset_i | flush_i}};
  assign stage_valid_o   = valid_q;
  assign exe_issue_o     = issue;
  assign exe_busy_o      = (cnt_q != '0);
  assign fetch_ready_o   = ready[0];
  assign halt_pipeline_o = ~ready[0];

endmodule

// File: tb/tb_lagarto_v_pipeline_sequencer.sv
// Scenario bench for lagarto_v_pipeline_sequencer against an occupancy-based reference model.
module tb_lagarto_v_pipeline_sequencer;
  localparam int N    = 3;
  localparam int MAXL = 32;
  localparam int LW   = 5;

  logic          clock_i = 1'b0;
  logic          reset_i, fetch_valid_i, flush_i, halt_i;
  logic [LW-1:0] issue_latency_i;
  logic          fetch_ready_o, exe_issue_o, exe_busy_o, halt_pipeline_o;
  logic [N-1:0]  stage_load_o, stage_flush_o, stage_valid_o;

  int passed = 0;
  int total  = 0;

  lagarto_v_pipeline_sequencer #(.NUM_STAGES(N), .MAX_LATENCY(MAXL)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o), .flush_i(flush_i), .halt_i(halt_i),
    .issue_latency_i(issue_latency_i), .stage_load_o(stage_load_o),
    .stage_flush_o(stage_flush_o), .stage_valid_o(stage_valid_o),
    .exe_issue_o(exe_issue_o), .exe_busy_o(exe_busy_o), .halt_pipeline_o(halt_pipeline_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference model: which slots hold an instruction, each slot's latency, remaining busy cycles.
  logic [N-1:0]   mv;
  int             mlat [N];
  int             mcnt;
  int             pend_lat;
  logic [N-1:0]   e_load, e_flush;
  logic           e_issue;
  logic [3*N+3:0] exp_all;

  function automatic logic [3*N+3:0] obs_all();
    return {stage_valid_o, stage_load_o, stage_flush_o, exe_issue_o, exe_busy_o,
            fetch_ready_o, halt_pipeline_o};
  endfunction

  task automatic drive(input logic fv, input logic fl, input logic ht, input logic rs,
                       input int new_lat);
    logic hole;
    reset_i         = rs;
    fetch_valid_i   = fv;
    flush_i         = fl;
    halt_i          = ht;
    issue_latency_i = LW'(mlat[N-1]);
    pend_lat        = new_lat;
    #1;
    e_issue = !rs && !fl && !ht && mv[N-1] && (mcnt == 0);
    for (int i = 0; i < N; i++) begin
      hole = 1'b0;
      for (int k = i; k < N; k++) if (!mv[k]) hole = 1'b1;
      e_load[i] = !(rs || fl || ht) && (hole || e_issue);
    end
    e_flush = (rs || fl) ? '1 : '0;
    exp_all = {mv, e_load, e_flush, e_issue, (mcnt != 0), e_load[0], !e_load[0]};
  endtask

  task automatic advance();
    @(posedge clock_i);
    if (reset_i) begin
      mv   = '0;
      mcnt = 0;
      for (int i = 0; i < N; i++) mlat[i] = 0;
    end else begin
      if (e_issue) mcnt = mlat[N-1];
      else if (mcnt > 0) mcnt = mcnt - 1;
      if (flush_i) begin
        mv = '0;
      end else begin
        for (int i = N-1; i >= 1; i--) begin
          if (e_load[i]) begin
            mv[i]   = mv[i-1];
            mlat[i] = mlat[i-1];
          end
        end
        if (e_load[0]) begin
          mv[0]   = fetch_valid_i;
          mlat[0] = pend_lat;
        end
      end
    end
    #1;
  endtask

  task automatic quiet_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
    advance();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 0);
      total++;
      if (obs_all() !== exp_all) $display("FAIL reset_outputs c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      total++;
      if (stage_flush_o !== 3'b111 || stage_load_o !== 3'b000 || fetch_ready_o !== 1'b0 || exe_issue_o !== 1'b0)
        $display("FAIL reset_hold c=%0d got flush=%b load=%b rdy=%b iss=%b want 111/000/0/0",
                 c, stage_flush_o, stage_load_o, fetch_ready_o, exe_issue_o);
      else passed++;
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    total++;
    if (stage_valid_o !== 3'b000 || exe_busy_o !== 1'b0 || halt_pipeline_o !== 1'b0 || fetch_ready_o !== 1'b1)
      $display("FAIL post_reset got valid=%b busy=%b halt=%b rdy=%b want 000/0/0/1",
               stage_valid_o, exe_busy_o, halt_pipeline_o, fetch_ready_o);
    else passed++;
    advance();
  endtask

  task automatic test_stream_lat0();
    int first_acc, first_iss, n_iss;
    logic rdy_ok;
    first_acc = -1; first_iss = -1; n_iss = 0; rdy_ok = 1'b1;
    quiet_reset();
    for (int c = 0; c < 16; c++) begin
      drive(c < 12, 1'b0, 1'b0, 1'b0, 0);
      total++;
      if (obs_all() !== exp_all) $display("FAIL stream c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      if (c < 12) begin
        if (fetch_ready_o && first_acc < 0) first_acc = c;
        if (fetch_ready_o !== 1'b1) rdy_ok = 1'b0;
        if (exe_issue_o === 1'b1) n_iss++;
      end
      if (exe_issue_o === 1'b1 && first_iss < 0) first_iss = c;
      advance();
    end
    total++;
    if (first_iss - first_acc !== 3) $display("FAIL stream_latency got=%0d want=3", first_iss - first_acc);
    else passed++;
    total++;
    if (n_iss !== 9 || rdy_ok !== 1'b1) $display("FAIL stream_rate got issues=%0d rdy_ok=%b want 9/1", n_iss, rdy_ok);
    else passed++;
  endtask

  task automatic test_latency5();
    int iss[$];
    int n_busy;
    n_busy = 0;
    quiet_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, (c == 0) ? 5 : 0);
      total++;
      if (obs_all() !== exp_all) $display("FAIL lat5 c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      if (exe_issue_o === 1'b1) iss.push_back(c);
      if (exe_busy_o === 1'b1) n_busy++;
      if (c == 7) begin
        total++;
        if (stage_valid_o !== 3'b111 || fetch_ready_o !== 1'b0 || halt_pipeline_o !== 1'b1)
          $display("FAIL lat5_stall got valid=%b rdy=%b halt=%b want 111/0/1", stage_valid_o, fetch_ready_o, halt_pipeline_o);
        else passed++;
      end
      advance();
    end
    total++;
    if (iss.size() < 2) $display("FAIL lat5_gap got issues=%0d want>=2", iss.size());
    else if (iss[1] - iss[0] !== 6) $display("FAIL lat5_gap got=%0d want=6", iss[1] - iss[0]);
    else passed++;
    total++;
    if (n_busy !== 5) $display("FAIL lat5_busy got=%0d want=5", n_busy);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
      total++;
      if (obs_all() !== exp_all) $display("FAIL lat5_drain c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      advance();
    end
  endtask

  task automatic test_bubble();
    quiet_reset();
    for (int c = 0; c < 22; c++) begin
      drive((c == 0) || (c == 4) || (c == 6) || (c == 9), 1'b0, 1'b0, 1'b0, (c == 0) ? 10 : 0);
      total++;
      if (obs_all() !== exp_all) $display("FAIL bubble c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      if (c == 8) begin
        total++;
        if (stage_valid_o !== 3'b110 || fetch_ready_o !== 1'b1)
          $display("FAIL bubble_collapse got valid=%b rdy=%b want 110/1", stage_valid_o, fetch_ready_o);
        else passed++;
      end
      if (c == 10) begin
        total++;
        if (stage_valid_o !== 3'b111 || fetch_ready_o !== 1'b0)
          $display("FAIL bubble_full got valid=%b rdy=%b want 111/0", stage_valid_o, fetch_ready_o);
        else passed++;
      end
      advance();
    end
  endtask

  task automatic test_flush();
    logic any_iss;
    any_iss = 1'b0;
    quiet_reset();
    for (int c = 0; c < 15; c++) begin
      drive(c <= 7, c == 7, 1'b0, 1'b0, (c == 0) ? 7 : 0);
      total++;
      if (obs_all() !== exp_all) $display("FAIL flush c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      if (c >= 7 && exe_issue_o !== 1'b0) any_iss = 1'b1;
      if (c == 7) begin
        total++;
        if (stage_valid_o !== 3'b111 || stage_flush_o !== 3'b111 || stage_load_o !== 3'b000 || fetch_ready_o !== 1'b0)
          $display("FAIL flush_pulse got valid=%b flush=%b load=%b rdy=%b want 111/111/000/0",
                   stage_valid_o, stage_flush_o, stage_load_o, fetch_ready_o);
        else passed++;
      end
      if (c == 8 || c == 10) begin
        total++;
        if (stage_valid_o !== 3'b000 || exe_busy_o !== 1'b1)
          $display("FAIL flush_after c=%0d got valid=%b busy=%b want 000/1", c, stage_valid_o, exe_busy_o);
        else passed++;
      end
      if (c == 11) begin
        total++;
        if (exe_busy_o !== 1'b0) $display("FAIL flush_cnt_done got busy=%b want 0", exe_busy_o);
        else passed++;
      end
      advance();
    end
    total++;
    if (any_iss !== 1'b0) $display("FAIL flush_no_issue got issue seen=%b want 0", any_iss);
    else passed++;
  endtask

  task automatic test_halt();
    logic [N-1:0] held;
    int iss_after;
    iss_after = 0;
    held = '0;
    quiet_reset();
    for (int c = 0; c < 36; c++) begin
      drive(c < 20, 1'b0, (c >= 8) && (c <= 11), 1'b0, 2);
      total++;
      if (obs_all() !== exp_all) $display("FAIL halt c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      if (c == 8) held = stage_valid_o;
      if (c >= 8 && c <= 11) begin
        total++;
        if (stage_load_o !== 3'b000 || exe_issue_o !== 1'b0 || stage_valid_o !== held)
          $display("FAIL halt_freeze c=%0d got load=%b iss=%b valid=%b want 000/0/%b",
                   c, stage_load_o, exe_issue_o, stage_valid_o, held);
        else passed++;
      end
      if (c >= 12 && c < 20 && exe_issue_o === 1'b1) iss_after++;
      advance();
    end
    total++;
    if (iss_after < 2) $display("FAIL halt_resume got issues=%0d want>=2", iss_after);
    else passed++;
  endtask

  task automatic test_reset_mid();
    quiet_reset();
    for (int c = 0; c < 8; c++) begin
      drive(c <= 4, 1'b0, 1'b0, c == 4, (c == 0) ? 20 : 0);
      total++;
      if (obs_all() !== exp_all) $display("FAIL reset_mid c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      if (c == 4) begin
        total++;
        if (stage_valid_o !== 3'b111 || exe_busy_o !== 1'b1 || stage_flush_o !== 3'b111 || stage_load_o !== 3'b000)
          $display("FAIL reset_mid_hold got valid=%b busy=%b flush=%b load=%b want 111/1/111/000",
                   stage_valid_o, exe_busy_o, stage_flush_o, stage_load_o);
        else passed++;
      end
      if (c == 5) begin
        total++;
        if (stage_valid_o !== 3'b000 || exe_busy_o !== 1'b0 || halt_pipeline_o !== 1'b0)
          $display("FAIL reset_mid_clear got valid=%b busy=%b halt=%b want 000/0/0",
                   stage_valid_o, exe_busy_o, halt_pipeline_o);
        else passed++;
      end
      advance();
    end
  endtask

  task automatic test_random();
    int lat;
    int sel;
    quiet_reset();
    for (int c = 0; c < 400; c++) begin
      sel = int'($urandom_range(0, 3));
      lat = (sel == 0) ? 0 : (sel == 1) ? MAXL - 1 : int'($urandom_range(0, 7));
      drive(($urandom % 3) != 0, ($urandom % 20) == 0, ($urandom % 8) == 0, ($urandom % 50) == 0, lat);
      total++;
      if (obs_all() !== exp_all) $display("FAIL random c=%0d got=%b want=%b", c, obs_all(), exp_all);
      else passed++;
      advance();
    end
  endtask

  initial begin
    mv = '0; mcnt = 0; pend_lat = 0;
    for (int i = 0; i < N; i++) mlat[i] = 0;
    reset_i = 1'b1; fetch_valid_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; issue_latency_i = '0;
    @(posedge clock_i);
    #1;
    test_reset();
    test_stream_lat0();
    test_latency5();
    test_bubble();
    test_flush();
    test_halt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
